signed_seq_divider: RTL and testbench
=====================================

// Module: signed_seq_divider
// PURPOSE
//  Iterative signed divider, the inverse of the team's Baugh-Wooley signed multiplier.
//  Divides a 2N-bit two's-complement dividend (product-width) by an N-bit
//  two's-complement divisor, yielding N-bit quotient and remainder.
//  Radix-2 restoring division on magnitudes, one quotient bit per clock.
//  Sits beside the multiplier in the arithmetic datapath, driven by a start/done handshake.
// PARAMETERS
//  WIDTH   4   operand width N; dividend is 2*WIDTH, quotient/remainder are WIDTH (WIDTH>=2)
// PORTS
//  clk        in   1        single clock, all state updates on posedge
//  rst        in   1        synchronous, active-high reset
//  start      in   1        request; accepted only when busy==0
//  dividend   in   2*WIDTH  signed dividend, sampled on the accepting edge
//  divisor    in   WIDTH    signed divisor, sampled on the accepting edge
//  busy       out  1        high from the accepting edge until the result edge
//  done       out  1        one-cycle pulse; results valid from this cycle
//  quotient   out  WIDTH    signed quotient, truncated toward zero
//  remainder  out  WIDTH    signed remainder; sign follows dividend; |r| < |divisor|
//  ovf        out  1        true quotient outside signed WIDTH range
//  dbz        out  1        divisor was zero
// BEHAVIOUR
//  - Clocking: one clock (clk). Reset rst is synchronous, active-high.
//  - Reset: FSM=IDLE; busy, done, quotient, remainder, ovf and dbz all 0.
//    rst mid-operation aborts: no done, and outputs cleared.
//  - FSM: IDLE -> CALC (2N cycles) -> FIX (1 cycle) -> IDLE.
//    IDLE & start: latch |dividend| (2N-bit unsigned; -2^(2N-1) fits), |divisor|,
//    sign_q = sgn(dd)^sgn(dv), sign_r = sgn(dd), and dbz_i = (divisor==0). busy<=1.
//    CALC: shift {rem,dd} left 1; if rem>=|dv| then rem-=|dv| and set q bit.
//    Run 2N iterations with a counter from 0 to 2N-1.
//    FIX: apply signs, evaluate overflow, and register the outputs.
//    done<=1, busy<=0, FSM<=IDLE at the same edge.
//  - Latency: constant. done is high in cycle 2N+2 after the accepting edge (N=4: 10).
//    Divide-by-zero uses the same latency.
//  - Outputs hold their last value until the next done or rst.
//    Operand inputs may change freely after acceptance.
//  - start while busy is ignored (not queued).
//    start in the done cycle is accepted, so back-to-back throughput is 1 per 2N+2 cycles.
//  - Overflow: for a negative result, ovf = |q| > 2^(N-1); for a positive result, ovf = |q| > 2^(N-1)-1.
//    The quotient on overflow is per CONFIGURATION.
//  - remainder is always the exact signed remainder; it always fits in WIDTH bits.
//  - dbz: quotient=0, remainder=0, ovf=0, dbz=1.
//  - Zero dividend: q=0, r=0 (no negative zero issue in two's complement).
// CONFIGURATION
//  SDIV_SAT_EN defined: on ovf, quotient saturates to 2^(N-1)-1 (positive result)
//    or -2^(N-1) (negative result).
//  SDIV_SAT_EN undefined: on ovf, quotient = low WIDTH bits of the true signed quotient (wrap).
//  ovf, dbz, remainder and latency are identical in both builds.
// TESTING (WIDTH=4)
//  - dd=30 (8'h1E), dv=-6 (4'hA) -> q=4'hB(-5), r=0, ovf=0, dbz=0.
//    done exactly 10 cycles after accept; busy high in between.
//  - dd=-7 (8'hF9), dv=2 -> q=4'hD(-3), r=4'hF(-1); dd=-64 (8'hC0), dv=8'... dv=4'h8(-8) -> q=8 overflows:
//    ovf=1, r=0; dd=-64, dv=4'h7? no: use dd=8'hC8(-56), dv=7 -> q=4'h8(-8), ovf=0, r=0.
//  - dd=100 (8'h64), dv=3 -> ovf=1, r=1; SAT build q=4'h7; wrap build q=4'h1 (33 mod 16).
//    Also dd=-128 (8'h80), dv=-8 -> ovf=1, r=0, q=4'h7 (SAT) / 4'h0 (wrap).
//  - dv=0, dd=8'h55 -> dbz=1, q=0, r=0, ovf=0, done after 10 cycles;
//    next op dd=12, dv=4 clears dbz, q=3, r=0.
//  - Back-to-back: start held high continuously -> done every 10 cycles.
//    A start pulse mid-CALC is ignored, with no extra done.
//  - rst asserted in cycle 4 of CALC -> next edge busy=0, all outputs 0, no done.
//    A new start 1 cycle later completes normally.

Source files
------------

// File: rtl/signed_seq_divider_if.sv
// Handshake and operand/result bundle for the signed sequential divider.
// The master side issues start with the operands and receives the results;
// the slave side is the divider itself.
interface signed_seq_divider_if #(
    parameter int WIDTH = 4
);
    logic                   start;
    logic [2*WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]       divisor;
    logic                   busy;
    logic                   done;
    logic [WIDTH-1:0]       quotient;
    logic [WIDTH-1:0]       remainder;
    logic                   ovf;
    logic                   dbz;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, ovf, dbz
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, ovf, dbz
    );
endinterface

// File: rtl/signed_seq_divider.sv
// Iterative signed divider: a 2*WIDTH-bit two's-complement dividend divided
// by a WIDTH-bit two's-complement divisor, giving WIDTH-bit quotient and
// remainder. Works on magnitudes with radix-2 restoring division, one
// quotient bit per clock, then applies signs in a final fix-up cycle.
// Optional macro SDIV_SAT_EN: when defined, an overflowing quotient
// saturates to the signed WIDTH-bit limit; otherwise it wraps to the low
// WIDTH bits of the true quotient.
module signed_seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    signed_seq_divider_if.slave     bus
);

    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(DW);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam logic [DW-1:0] POS_LIMIT = DW'((1 << (WIDTH - 1)) - 1);
    localparam logic [DW-1:0] NEG_LIMIT = DW'(1 << (WIDTH - 1));

    logic [1:0]         r_state;
    logic [CW-1:0]      r_count;
    logic [DW-1:0]      r_ddQ;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_dvAbs;
    logic               r_signQ;
    logic               r_signR;
    logic               r_dbzPending;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_ovf;
    logic               r_dbz;

    logic [DW-1:0]      w_ddAbs;
    logic [WIDTH-1:0]   w_dvAbs;
    logic               w_accept;
    logic               w_lastIter;
    logic [WIDTH:0]     w_shift;
    logic               w_geq;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_remNext;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_qWrap;
    logic [WIDTH-1:0]   w_qFinal;
    logic [WIDTH-1:0]   w_rSigned;

    assign w_ddAbs    = bus.dividend[DW-1] ? -bus.dividend : bus.dividend;
    assign w_dvAbs    = bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
    assign w_accept   = (r_state == ST_IDLE) && bus.start;
    assign w_lastIter = (r_count == CW'(DW - 1));

    // The partial remainder never exceeds |divisor| <= 2^(WIDTH-1), so after
    // shifting in the next dividend bit it fits in WIDTH+1 bits, and the
    // restored or reduced value fits back into WIDTH bits.
    assign w_shift   = {r_rem, r_ddQ[DW-1]};
    assign w_geq     = (w_shift >= {1'b0, r_dvAbs});
    assign w_diff    = w_shift[WIDTH-1:0] - r_dvAbs;
    assign w_remNext = w_geq ? w_diff : w_shift[WIDTH-1:0];

    // Once all bits are processed r_ddQ holds the quotient magnitude and
    // r_rem the remainder magnitude. A negative quotient may reach
    // -2^(WIDTH-1), a positive one only 2^(WIDTH-1)-1.
    assign w_ovf     = r_signQ ? (r_ddQ > NEG_LIMIT) : (r_ddQ > POS_LIMIT);
    assign w_qWrap   = r_signQ ? -r_ddQ[WIDTH-1:0] : r_ddQ[WIDTH-1:0];
    assign w_rSigned = r_signR ? -r_rem : r_rem;

`ifdef SDIV_SAT_EN
    logic [WIDTH-1:0]   w_qSat;

    assign w_qSat   = r_signQ ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    assign w_qFinal = w_ovf ? w_qSat : w_qWrap;
`else
    assign w_qFinal = w_qWrap;
`endif

    // Sequencing: accept a request in IDLE, walk through 2*WIDTH iterations,
    // then spend one cycle fixing up signs before returning to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_count <= r_count + 1'b1;
                    if (w_lastIter) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Operand capture on acceptance and one restoring step per CALC cycle;
    // quotient bits shift into the vacated low end of the dividend register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ddQ        <= '0;
            r_rem        <= '0;
            r_dvAbs      <= '0;
            r_signQ      <= 1'b0;
            r_signR      <= 1'b0;
            r_dbzPending <= 1'b0;
        end else if (w_accept) begin
            r_ddQ        <= w_ddAbs;
            r_rem        <= '0;
            r_dvAbs      <= w_dvAbs;
            r_signQ      <= bus.dividend[DW-1] ^ bus.divisor[WIDTH-1];
            r_signR      <= bus.dividend[DW-1];
            r_dbzPending <= (bus.divisor == '0);
        end else if (r_state == ST_CALC) begin
            r_rem <= w_remNext;
            r_ddQ <= {r_ddQ[DW-2:0], w_geq};
        end
    end

    // Result registers update only in the fix-up cycle and otherwise hold,
    // so the last result stays visible until the next one or a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_quotient  <= '0;
            r_remainder <= '0;
            r_ovf       <= 1'b0;
            r_dbz       <= 1'b0;
        end else if (r_state == ST_FIX) begin
            if (r_dbzPending) begin
                r_quotient  <= '0;
                r_remainder <= '0;
                r_ovf       <= 1'b0;
                r_dbz       <= 1'b1;
            end else begin
                r_quotient  <= w_qFinal;
                r_remainder <= w_rSigned;
                r_ovf       <= w_ovf;
                r_dbz       <= 1'b0;
            end
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
    assign bus.ovf       = r_ovf;
    assign bus.dbz       = r_dbz;

endmodule

// File: tb/tb_signed_seq_divider.sv
// Self-checking bench for signed_seq_divider (WIDTH=4). Expected results
// come from native integer division and are queued at issue time; a
// monitor pops and compares them whenever done pulses. Honors SDIV_SAT_EN
// in the reference model.
module tb_signed_seq_divider;

    localparam int W   = 4;
    localparam int DW  = 2 * W;
    localparam int LAT = 2 * W + 2;

    typedef struct {
        int           dd;
        int           dv;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         ovf;
        logic         dbz;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    exp_t sb[$];
    exp_t monExp;
    int   checks = 0;
    int   errors = 0;

    signed_seq_divider_if #(.WIDTH(W)) bus ();

    signed_seq_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    // Reference: truncating division with the remainder sign following the dividend
    function automatic exp_t model(input int dd, input int dv);
        exp_t e;
        int   tq;
        int   tr;
        int   qMax;
        int   qMin;
        qMax  = (1 << (W - 1)) - 1;
        qMin  = -(1 << (W - 1));
        e.dd  = dd;
        e.dv  = dv;
        if (dv == 0) begin
            e.q   = '0;
            e.r   = '0;
            e.ovf = 1'b0;
            e.dbz = 1'b1;
        end else begin
            tq    = dd / dv;
            tr    = dd % dv;
            e.dbz = 1'b0;
            e.ovf = (tq > qMax) || (tq < qMin);
            e.r   = tr[W-1:0];
            e.q   = tq[W-1:0];
`ifdef SDIV_SAT_EN
            if (e.ovf) e.q = (tq > 0) ? qMax[W-1:0] : qMin[W-1:0];
`endif
        end
        return e;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest pending request
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: done=1 with no request pending (q=%h r=%h)",
                         bus.quotient, bus.remainder);
            end else begin
                monExp = sb.pop_front();
                checks++;
                if (bus.quotient !== monExp.q) begin
                    errors++;
                    $display("[TB] FAIL quotient %0d/%0d: got %h expected %h",
                             monExp.dd, monExp.dv, bus.quotient, monExp.q);
                end
                checks++;
                if (bus.remainder !== monExp.r) begin
                    errors++;
                    $display("[TB] FAIL remainder %0d/%0d: got %h expected %h",
                             monExp.dd, monExp.dv, bus.remainder, monExp.r);
                end
                checks++;
                if (bus.ovf !== monExp.ovf) begin
                    errors++;
                    $display("[TB] FAIL ovf %0d/%0d: got %b expected %b",
                             monExp.dd, monExp.dv, bus.ovf, monExp.ovf);
                end
                checks++;
                if (bus.dbz !== monExp.dbz) begin
                    errors++;
                    $display("[TB] FAIL dbz %0d/%0d: got %b expected %b",
                             monExp.dd, monExp.dv, bus.dbz, monExp.dbz);
                end
            end
        end
    end

    // Hard stop in case anything wedges
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one request across the accepting edge and queue its expected result
    task automatic applyStimulus(input int dd, input int dv);
        bus.start    = 1'b1;
        bus.dividend = dd[DW-1:0];
        bus.divisor  = dv[W-1:0];
        sb.push_back(model(dd, dv));
        step();
        bus.start = 1'b0;
    endtask

    // Bounded wait for done; cycles = index of the cycle where done is seen (-1 on timeout)
    task automatic waitDone(input int firstCycle, input int limit, output int cycles);
        cycles = firstCycle;
        while (bus.done !== 1'b1 && cycles < limit) begin
            step();
            cycles++;
        end
        if (bus.done !== 1'b1) cycles = -1;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) step();
        checks++;
        if ({bus.busy, bus.done, bus.ovf, bus.dbz, bus.quotient, bus.remainder} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: busy=%b done=%b ovf=%b dbz=%b q=%h r=%h, required all 0",
                     bus.busy, bus.done, bus.ovf, bus.dbz, bus.quotient, bus.remainder);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int vecs[10][2] = '{'{30, -6}, '{-7, 2}, '{-56, 7}, '{12, 4}, '{0, 5},
                            '{0, -3}, '{-1, 2}, '{7, -8}, '{127, -8}, '{-9, -4}};
        int cyc;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i][0], vecs[i][1]);
            checks++;
            if (bus.busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL busy_after_accept %0d/%0d: got %b required 1",
                         vecs[i][0], vecs[i][1], bus.busy);
            end
            waitDone(1, LAT + 5, cyc);
            checks++;
            if (cyc !== LAT) begin
                errors++;
                $display("[TB] FAIL latency %0d/%0d: got %0d required %0d",
                         vecs[i][0], vecs[i][1], cyc, LAT);
            end
            checks++;
            if (bus.busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL busy_at_done %0d/%0d: got %b required 0",
                         vecs[i][0], vecs[i][1], bus.busy);
            end
        end
        step();
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_pulse_width: got %b required 0", bus.done);
        end
    endtask

    task automatic test_overflow();
        int vecs[5][3] = '{'{-64, -8, 1}, '{100, 3, 1}, '{-128, -8, 1},
                           '{-128, 1, 1}, '{-56, 7, 0}};
        int cyc;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i][0], vecs[i][1]);
            waitDone(1, LAT + 5, cyc);
            checks++;
            if (cyc !== LAT || bus.ovf !== vecs[i][2][0]) begin
                errors++;
                $display("[TB] FAIL ovf_case %0d/%0d: latency %0d ovf %b, required latency %0d ovf %0d",
                         vecs[i][0], vecs[i][1], cyc, bus.ovf, LAT, vecs[i][2]);
            end
        end
    endtask

    task automatic test_dbz();
        int cyc;
        applyStimulus(85, 0);
        waitDone(1, LAT + 5, cyc);
        checks++;
        if (cyc !== LAT || bus.dbz !== 1'b1) begin
            errors++;
            $display("[TB] FAIL dbz_flag: latency %0d dbz %b, required latency %0d dbz 1",
                     cyc, bus.dbz, LAT);
        end
        repeat (3) step();
        checks++;
        if (bus.dbz !== 1'b1 || bus.quotient !== 4'h0 || bus.done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dbz_hold: dbz=%b q=%h done=%b, required dbz=1 q=0 done=0",
                     bus.dbz, bus.quotient, bus.done);
        end
        applyStimulus(12, 4);
        waitDone(1, LAT + 5, cyc);
        checks++;
        if (bus.dbz !== 1'b0 || bus.quotient !== 4'h3) begin
            errors++;
            $display("[TB] FAIL dbz_clear: dbz=%b q=%h, required dbz=0 q=3",
                     bus.dbz, bus.quotient);
        end
    endtask

    task automatic test_ignore_start();
        int cyc;
        int extra;
        applyStimulus(100, 3);
        repeat (3) step();
        bus.start    = 1'b1;
        bus.dividend = 8'h11;
        bus.divisor  = 4'h1;
        step();
        bus.start = 1'b0;
        waitDone(5, LAT + 5, cyc);
        checks++;
        if (cyc !== LAT) begin
            errors++;
            $display("[TB] FAIL ignore_start_latency: got %0d required %0d", cyc, LAT);
        end
        extra = 0;
        for (int i = 0; i < 2 * LAT; i++) begin
            step();
            if (bus.done === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("[TB] FAIL ignore_start_extra_done: got %0d required 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int vecs[3][2] = '{'{30, -6}, '{-128, -8}, '{100, 3}};
        int cyc;
        int extra;
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.dividend = vecs[i][0][DW-1:0];
            bus.divisor  = vecs[i][1][W-1:0];
            sb.push_back(model(vecs[i][0], vecs[i][1]));
            step();
            if (i == 2) bus.start = 1'b0;
            waitDone(1, LAT + 5, cyc);
            checks++;
            if (cyc !== LAT) begin
                errors++;
                $display("[TB] FAIL back_to_back_interval op%0d: got %0d required %0d", i, cyc, LAT);
            end
        end
        extra = 0;
        for (int i = 0; i < LAT + 2; i++) begin
            step();
            if (bus.done === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("[TB] FAIL back_to_back_extra_done: got %0d required 0", extra);
        end
    endtask

    task automatic test_reset_abort();
        int cyc;
        applyStimulus(-7, 2);
        waitDone(1, LAT + 5, cyc);
        applyStimulus(30, -6);
        repeat (3) step();
        rst = 1'b1;
        step();
        void'(sb.pop_back());
        checks++;
        if ({bus.busy, bus.done, bus.ovf, bus.dbz, bus.quotient, bus.remainder} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_abort: busy=%b done=%b ovf=%b dbz=%b q=%h r=%h, required all 0",
                     bus.busy, bus.done, bus.ovf, bus.dbz, bus.quotient, bus.remainder);
        end
        rst = 1'b0;
        step();
        applyStimulus(-56, 7);
        waitDone(1, LAT + 5, cyc);
        checks++;
        if (cyc !== LAT) begin
            errors++;
            $display("[TB] FAIL restart_after_abort: latency %0d required %0d", cyc, LAT);
        end
    endtask

    task automatic test_random();
        int cyc;
        int dd;
        int dv;
        for (int i = 0; i < 24; i++) begin
            dd = int'($urandom_range(255, 0)) - 128;
            dv = int'($urandom_range(15, 0)) - 8;
            applyStimulus(dd, dv);
            waitDone(1, LAT + 5, cyc);
            checks++;
            if (cyc !== LAT) begin
                errors++;
                $display("[TB] FAIL random_latency %0d/%0d: got %0d required %0d", dd, dv, cyc, LAT);
            end
        end
    endtask

    // End-of-run check that every issued request produced exactly one result
    task automatic checkOutput();
        repeat (2) step();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        $display("[TB] signed_seq_divider bench, WIDTH=%0d", W);
        test_reset();
        test_basic();
        test_overflow();
        test_dbz();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_random();
        checkOutput();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
